elevator_ctrl_n: RTL and testbench
==================================

Name: elevator_ctrl_n

Overview:
- Parametrised successor to the single-car 4-floor controller/floor-register/countdown trio, merged into one block for an N-floor car.
- Latches hall and car requests, schedules with directional SCAN (collective control), tracks the car floor from the level-transducer edge, and times door dwell internally.
- Adds a travel-timeout fault (warning), re-open/hold, forced close and per-floor request lamps.
- Sits between the button/sensor synchroniser front end and the display/lamp drivers.

Parameters:
- FLOORS, 8, number of floors (>=2); floors indexed 0..FLOORS-1.
- DOOR_TICKS, 10, door dwell in tick periods.
- TRAVEL_TIMEOUT, 20, max tick periods between floor-level edges while moving before fault.
- FW, $clog2(FLOORS), floor index width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle timebase strobe (1 Hz in product), qualifies all timers.
- level_trans  in  1  floor-level sensor, high while car is aligned to a floor level.
- hall_up  in  FLOORS  up-call buttons, bit f = floor f (top bit ignored).
- hall_down  in  FLOORS  down-call buttons (bit 0 ignored).
- car_call  in  FLOORS  in-car floor buttons.
- open_btn  in  1  door open/hold button.
- close_btn  in  1  door close button.
- floor  out  FW  current floor.
- direct  out  2  00 idle, 01 up, 10 down.
- moving  out  1  car motor enabled.
- door  out  1  1 = door open.
- left  out  $clog2(DOOR_TICKS+1)  remaining dwell ticks.
- warning  out  1  travel fault.
- lamps  out  3*FLOORS  {car_call, hall_down, hall_up} latched requests.

Behaviour:
- Reset: all outputs 0, all request latches cleared, state IDLE, floor 0. Reset asserted mid-operation aborts immediately; no latched state survives.
- Buttons are level inputs. A request latches on any cycle the input is high, except while the car is at that floor with the door open (it reloads dwell instead). Out-of-range bits (hall_up[FLOORS-1], hall_down[0]) never latch.
- States: IDLE, MOVE, DOOR, FAULT.
- IDLE:
  - Request at current floor -> DOOR.
  - Else nearest pending request sets direct; ties go up. Go to MOVE and assert moving.
- MOVE:
  - Each rising edge of level_trans steps floor by ±1 per direct, saturating at 0 and FLOORS-1.
  - After stepping, stop if car_call[floor], or the hall call in direct at floor, or no pending request beyond floor in direct (then any call at floor). Stop means moving=0, go to DOOR.
  - No level_trans rising edge within TRAVEL_TIMEOUT ticks of the last edge or move start -> FAULT.
- DOOR:
  - On entry: door=1, left=DOOR_TICKS, and the serviced latches at floor are cleared (car_call plus the hall call in the departure direction).
  - Each tick decrements left.
  - open_btn, or a new call at floor, reloads left=DOOR_TICKS.
  - close_btn sets left=0 the next cycle; open_btn wins if both are asserted.
  - At left==0, door=0 the following cycle. Then continue in direct if requests remain ahead, reverse if only behind, else go to IDLE with direct=00.
- FAULT: warning=1, moving=0, door=0, requests still latch. Exit only by rst.
- Simultaneous level_trans edge and tick: the edge is processed and the timeout counter restarts.
- Latency:
  - Button to lamp: 1 cycle.
  - Stop decision to moving=0: 1 cycle after the edge.

Decomposition:
- Shared package elevator_pkg: state enum (IDLE/MOVE/DOOR/FAULT), direction codes DIR_IDLE/DIR_UP/DIR_DOWN.
- Sub-module req_scan: combinational any_above/any_below/stop_here from the latch vectors, floor and direct.
- Door timer and travel timer stay inline as counters.

Test Plan (FLOORS=4, DOOR_TICKS=3, TRAVEL_TIMEOUT=5; level_trans edge every 2 ticks):
- Reset, then hall_up[0] pulse -> lamps bit0=1. Then door=1, left=3, 2, 1, 0, then door=0. Ends IDLE, direct=00, floor=0.
- car_call[3] from floor 0 -> direct=01, floor steps 1, 2, 3. moving drops after the edge at 3, door=1, lamp cleared.
- Moving up from 0 with car_call[3]; hall_down[1] while passing 1 -> no stop at 1. Stops at 3, reverses to direct=10, stops at 1.
- Door open, left=1, open_btn -> left=3. close_btn -> left=0 next cycle, door=0 one cycle later.
- Moving, hold level_trans low 5 ticks -> warning=1, moving=0, door=0, state persists. rst clears all outputs to 0.
- hall_up[3] and hall_down[0] pressed -> lamps stay 0 and the car stays IDLE.

Source files
------------

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state and direction encodings for the elevator controller
package elevator_pkg;
  typedef enum logic [1:0] {IDLE, MOVE, DOOR, FAULT} state_t;
  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
endpackage

// File: rtl/elevator_req_scan.sv
// req_scan: request lookup around a floor (stop decision and SCAN departure direction)
module req_scan
  import elevator_pkg::*;
#(
  parameter int FLOORS = 8,
  localparam int FW = $clog2(FLOORS)
) (
  input  logic [FLOORS-1:0] up,
  input  logic [FLOORS-1:0] dn,
  input  logic [FLOORS-1:0] car,
  input  logic [FW-1:0]     floor,
  input  logic [1:0]        dir,
  output logic              here,
  output logic              stop_here,
  output logic [1:0]        dep_dir
);
  logic [FLOORS-1:0] all;
  logic any_above, any_below, ahead, go_up;
  int fl, du, dd;
  always_comb begin
    all = up | dn | car;
    fl = int'(floor);
    any_above = 1'b0;
    any_below = 1'b0;
    du = FLOORS;
    dd = FLOORS;
    for (int f = 0; f < FLOORS; f++) begin
      if (all[f] && f > fl) begin
        any_above = 1'b1;
        if (f - fl < du) du = f - fl;
      end
      if (all[f] && f < fl) begin
        any_below = 1'b1;
        if (fl - f < dd) dd = fl - f;
      end
    end
    here = all[floor];
    ahead = dir == DIR_UP ? any_above : dir == DIR_DOWN ? any_below : 1'b0;
    stop_here = car[floor] | (dir == DIR_UP ? up[floor] : dn[floor]) | !ahead;
    go_up = any_above && (!any_below || du <= dd);
    dep_dir = dir == DIR_UP   ? (any_above ? DIR_UP : any_below ? DIR_DOWN : DIR_IDLE) :
              dir == DIR_DOWN ? (any_below ? DIR_DOWN : any_above ? DIR_UP : DIR_IDLE) :
              go_up ? DIR_UP : any_below ? DIR_DOWN : DIR_IDLE;
  end
endmodule

// File: rtl/elevator_ctrl_n.sv
// elevator_ctrl_n: N-floor single-car controller with SCAN scheduling, door dwell and travel fault
module elevator_ctrl_n
  import elevator_pkg::*;
#(
  parameter int FLOORS = 8,
  parameter int DOOR_TICKS = 10,
  parameter int TRAVEL_TIMEOUT = 20,
  localparam int FW = $clog2(FLOORS),
  localparam int LW = $clog2(DOOR_TICKS + 1),
  localparam int TW = $clog2(TRAVEL_TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  level_trans,
  input  logic [FLOORS-1:0]     hall_up,
  input  logic [FLOORS-1:0]     hall_down,
  input  logic [FLOORS-1:0]     car_call,
  input  logic                  open_btn,
  input  logic                  close_btn,
  output logic [FW-1:0]         floor,
  output logic [1:0]            direct,
  output logic                  moving,
  output logic                  door,
  output logic [LW-1:0]         left,
  output logic                  warning,
  output logic [3*FLOORS-1:0]   lamps
);
  localparam logic [FLOORS-1:0] UP_OK = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_OK = {{(FLOORS-1){1'b1}}, 1'b0};
  state_t state, state_nx;
  logic [FLOORS-1:0] up_q, dn_q, car_q, up_nx, dn_nx, car_nx, pu, pd, keep;
  logic [FW-1:0] floor_nx, step_floor, scan_floor;
  logic [1:0] direct_nx, dep_dir;
  logic [LW-1:0] left_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic lt_q, rise, here, stop_here, at_call, clr;
  assign rise = level_trans & ~lt_q;
  assign pu = hall_up & UP_OK;
  assign pd = hall_down & DN_OK;
  assign step_floor = direct == DIR_UP   ? (floor == FW'(FLOORS-1) ? floor : floor + 1'b1) :
                      direct == DIR_DOWN ? (floor == '0 ? floor : floor - 1'b1) : floor;
  assign scan_floor = (state == MOVE && rise) ? step_floor : floor;
  // With the door open, presses at the current floor only hold the door, they never latch
  assign keep = state == DOOR ? ~(FLOORS'(1) << floor) : '1;
  assign at_call = pu[floor] | pd[floor] | car_call[floor];
  assign moving = state == MOVE;
  assign door = state == DOOR;
  assign warning = state == FAULT;
  assign lamps = {car_q, dn_q, up_q};
  req_scan #(.FLOORS(FLOORS)) u_scan (
    .up(up_q), .dn(dn_q), .car(car_q), .floor(scan_floor), .dir(direct),
    .here(here), .stop_here(stop_here), .dep_dir(dep_dir)
  );
  always_comb begin
    state_nx = state;
    floor_nx = floor;
    direct_nx = direct;
    left_nx = left;
    tcnt_nx = tcnt;
    clr = 1'b0;
    up_nx = up_q | (pu & keep);
    dn_nx = dn_q | (pd & keep);
    car_nx = car_q | (car_call & keep);
    case (state)
      IDLE: begin
        if (here) begin
          state_nx = DOOR;
          left_nx = LW'(DOOR_TICKS);
          clr = 1'b1;
        end else if (dep_dir != DIR_IDLE) begin
          state_nx = MOVE;
          direct_nx = dep_dir;
          tcnt_nx = '0;
        end
      end
      MOVE: begin
        if (rise) begin
          floor_nx = step_floor;
          tcnt_nx = '0;
          if (stop_here) begin
            state_nx = DOOR;
            left_nx = LW'(DOOR_TICKS);
            clr = 1'b1;
          end
        end else if (tick) begin
          if (tcnt == TW'(TRAVEL_TIMEOUT-1)) state_nx = FAULT;
          else tcnt_nx = tcnt + 1'b1;
        end
      end
      DOOR: begin
        if (open_btn | at_call) left_nx = LW'(DOOR_TICKS);
        else if (left == '0) begin
          direct_nx = dep_dir;
          state_nx = dep_dir == DIR_IDLE ? IDLE : MOVE;
          tcnt_nx = '0;
        end else if (close_btn) left_nx = '0;
        else if (tick) left_nx = left - 1'b1;
      end
      FAULT: ;
    endcase
    // Serviced calls: the car call plus the hall call matching the way the car will leave
    if (clr) begin
      car_nx[scan_floor] = 1'b0;
      if (dep_dir != DIR_DOWN) up_nx[scan_floor] = 1'b0;
      if (dep_dir != DIR_UP) dn_nx[scan_floor] = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      floor <= '0;
      direct <= DIR_IDLE;
      left <= '0;
      tcnt <= '0;
      lt_q <= 1'b0;
      up_q <= '0;
      dn_q <= '0;
      car_q <= '0;
    end else begin
      state <= state_nx;
      floor <= floor_nx;
      direct <= direct_nx;
      left <= left_nx;
      tcnt <= tcnt_nx;
      lt_q <= level_trans;
      up_q <= up_nx;
      dn_q <= dn_nx;
      car_q <= car_nx;
    end
  end
endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb_elevator_ctrl_n: scoreboard bench comparing output changes against a behavioural car model
module tb_elevator_ctrl_n;
  localparam int F = 4, DT = 3, TT = 5, FW = 2, LW = 2;
  localparam int NW = FW + 2 + 1 + 1 + LW + 1 + 3*F;
  logic clk = 0, rst = 1, tick = 0, level_trans = 0, open_btn = 0, close_btn = 0;
  logic [F-1:0] hall_up = '0, hall_down = '0, car_call = '0;
  logic [FW-1:0] floor;
  logic [1:0] direct;
  logic moving, door, warning;
  logic [LW-1:0] left;
  logic [3*F-1:0] lamps;
  elevator_ctrl_n #(.FLOORS(F), .DOOR_TICKS(DT), .TRAVEL_TIMEOUT(TT)) dut (
    .clk(clk), .rst(rst), .tick(tick), .level_trans(level_trans),
    .hall_up(hall_up), .hall_down(hall_down), .car_call(car_call),
    .open_btn(open_btn), .close_btn(close_btn),
    .floor(floor), .direct(direct), .moving(moving), .door(door),
    .left(left), .warning(warning), .lamps(lamps)
  );
  always #5 clk = ~clk;
  wire [NW-1:0] dut_t = {floor, direct, moving, door, left, warning, lamps};
  int total = 0, bad = 0, cyc_no = 0, env_cnt = 0, snap_req = 0, snap_done = 0, fault_age = 0;
  bit stall = 0, fin = 0, fin_done = 0;
  string snap_name = "";
  int ms = 0, mf = 0, md = 0, ml = 0, mtc = 0;
  bit mltp = 0;
  bit [F-1:0] mu = '0, mdn = '0, mc = '0;
  logic [NW-1:0] q[$];
  logic [NW-1:0] last_exp = '0, prev_dut = '0, mon_e;
  function automatic bit pend(int i);
    return mu[i] | mdn[i] | mc[i];
  endfunction
  // SCAN choice: keep heading the same way while work remains, else turn, else nearest (ties up)
  function automatic int depart(int f, int d);
    int du = F, dd = F;
    for (int i = 0; i < F; i++)
      if (pend(i)) begin
        if (i > f && i - f < du) du = i - f;
        if (i < f && f - i < dd) dd = f - i;
      end
    if (d > 0) return du < F ? 1 : dd < F ? -1 : 0;
    if (d < 0) return dd < F ? -1 : du < F ? 1 : 0;
    return (du < F && du <= dd) ? 1 : dd < F ? -1 : 0;
  endfunction
  function automatic logic [NW-1:0] exp_t();
    logic [1:0] dc;
    dc = md > 0 ? 2'b01 : md < 0 ? 2'b10 : 2'b00;
    return {FW'(mf), dc, ms == 1, ms == 2, LW'(ml), ms == 3, mc, mdn, mu};
  endfunction
  task automatic model_step();
    int os, of, cf, cd, nf;
    bit rise, clr, ahead, here_call;
    os = ms; of = mf; cf = 0; cd = 0; clr = 0;
    if (rst) begin
      ms = 0; mf = 0; md = 0; ml = 0; mtc = 0; mltp = 0; mu = '0; mdn = '0; mc = '0;
      return;
    end
    rise = level_trans && !mltp;
    mltp = level_trans;
    if (ms == 0) begin
      cd = depart(mf, 0);
      if (pend(mf)) begin ms = 2; ml = DT; cf = mf; clr = 1; end
      else if (cd != 0) begin ms = 1; md = cd; mtc = 0; end
    end else if (ms == 1) begin
      if (rise) begin
        nf = mf + md;
        if (nf < 0) nf = 0;
        if (nf > F - 1) nf = F - 1;
        mf = nf; mtc = 0;
        ahead = 0;
        for (int i = 0; i < F; i++) if (pend(i) && (md > 0 ? i > nf : i < nf)) ahead = 1;
        if (mc[nf] || (md > 0 ? mu[nf] : mdn[nf]) || !ahead) begin
          ms = 2; ml = DT; cf = nf; cd = depart(nf, md); clr = 1;
        end
      end else if (tick) begin
        mtc++;
        if (mtc >= TT) ms = 3;
      end
    end else if (ms == 2) begin
      here_call = (hall_up[mf] && mf < F - 1) || (hall_down[mf] && mf > 0) || car_call[mf];
      if (open_btn || here_call) ml = DT;
      else if (ml == 0) begin md = depart(mf, md); ms = md != 0 ? 1 : 0; mtc = 0; end
      else if (close_btn) ml = 0;
      else if (tick) ml--;
    end
    for (int i = 0; i < F; i++)
      if (!(os == 2 && i == of)) begin
        if (hall_up[i] && i < F - 1) mu[i] = 1;
        if (hall_down[i] && i > 0) mdn[i] = 1;
        if (car_call[i]) mc[i] = 1;
      end
    if (clr) begin
      mc[cf] = 0;
      if (cd >= 0) mu[cf] = 0;
      if (cd <= 0) mdn[cf] = 0;
    end
  endtask
  // Environment: one tick every 4 cycles; a moving car reaches a level every second tick
  task automatic cyc();
    tick = (cyc_no % 4 == 0);
    cyc_no++;
    level_trans = (ms == 1 && !stall && tick && env_cnt == 1);
    env_cnt = ms != 1 ? 0 : tick ? (env_cnt == 1 ? 0 : 1) : env_cnt;
    model_step();
    if (exp_t() != last_exp) begin
      last_exp = exp_t();
      q.push_back(last_exp);
    end
    @(negedge clk);
  endtask
  task automatic run(int n);
    repeat (n) cyc();
  endtask
  task automatic press(int k, int f);
    if (k == 0) hall_up[f] = 1'b1;
    else if (k == 1) hall_down[f] = 1'b1;
    else car_call[f] = 1'b1;
    cyc();
    hall_up = '0; hall_down = '0; car_call = '0;
  endtask
  task automatic snap(string n);
    snap_name = n;
    snap_req++;
    cyc();
  endtask
  always @(posedge clk) begin
    #1;
    if (dut_t !== prev_dut) begin
      prev_dut = dut_t;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL evt_unexpected got=%h exp=none", dut_t);
      end else begin
        mon_e = q.pop_front();
        if (mon_e !== dut_t) begin
          bad++;
          $display("FAIL evt got=%h exp=%h", dut_t, mon_e);
        end
      end
    end
    if (snap_done != snap_req) begin
      snap_done = snap_req;
      total++;
      if (dut_t !== last_exp) begin
        bad++;
        $display("FAIL snap_%s got=%h exp=%h", snap_name, dut_t, last_exp);
      end
    end
    if (fin && !fin_done) begin
      fin_done = 1;
      total++;
      if (q.size() != 0) begin
        bad++;
        $display("FAIL missing_evt pending=%0d exp=%h", q.size(), q[0]);
      end
    end
  end
  initial begin
    @(negedge clk);
    run(3);
    snap("reset");
    rst = 0;
    press(0, 0);
    snap("lamp_up0");
    run(40);
    snap("idle_f0");
    press(2, 3);
    run(60);
    snap("car3");
    rst = 1; run(2); rst = 0;
    press(2, 3);
    run(7);
    hall_down[1] = 1'b1; run(4); hall_down = '0;
    run(120);
    snap("reverse_f1");
    press(2, 0);
    for (int i = 0; i < 200 && !(ms == 2 && ml == 1); i++) cyc();
    open_btn = 1; cyc(); open_btn = 0;
    snap("open_reload");
    run(2);
    close_btn = 1; cyc(); close_btn = 0;
    snap("close_zero");
    snap("door_shut");
    run(30);
    rst = 1; run(2); rst = 0;
    press(2, 3);
    run(6);
    stall = 1;
    run(40);
    snap("fault");
    press(0, 2);
    snap("fault_latch");
    rst = 1; cyc();
    snap("rst_clear");
    rst = 0; stall = 0;
    hall_up[3] = 1'b1; hall_down[0] = 1'b1; cyc();
    hall_up = '0; hall_down = '0;
    run(10);
    snap("out_of_range");
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 999) == 0) begin rst = 1; run(2); rst = 0; end
      if ($urandom_range(0, 599) == 0) stall = 1;
      if (ms == 3) begin
        fault_age++;
        if (fault_age > 30) begin rst = 1; run(2); rst = 0; stall = 0; fault_age = 0; end
      end
      if (r < 5) press($urandom_range(0, 2), $urandom_range(0, F - 1));
      else if (r == 50) begin open_btn = 1; cyc(); open_btn = 0; end
      else if (r == 51) begin close_btn = 1; cyc(); close_btn = 0; end
      else cyc();
    end
    snap("random_end");
    run(20);
    fin = 1;
    run(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
